// File: rtl/pipe_field_scroller_pkg.sv
// Shared definitions for the dot runner obstacle field:
// default geometry, LFSR taps/seed and the LFSR step.
package pipe_field_scroller_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_H_W  = 5;
  localparam int DEF_GAP  = 6;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] q
  );
    return {1'b0, q[15:1]} ^
      (q[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/pipe_field_scroller_if.sv
// Control, collision and display-read signals of
// the obstacle field, bundled between game and field.
interface pipe_field_scroller_if #(
  parameter int H_W = 5,
  parameter int RW  = 7
);

  logic           start;
  logic           run;
  logic [H_W-1:0] bird_h;
  logic [RW-1:0]  rd_col;
  logic           rd_pipe;
  logic [H_W-1:0] rd_gap_lo;
  logic           tick;
  logic           hit;
  logic [15:0]    score;

  modport master (
    output start, run, bird_h, rd_col,
    input  rd_pipe, rd_gap_lo, tick, hit, score
  );

  modport slave (
    input  start, run, bird_h, rd_col,
    output rd_pipe, rd_gap_lo, tick, hit, score
  );

endinterface

// File: rtl/dr_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and
// explicit advance; holds when adv is low.
module dr_lfsr16
  import pipe_field_scroller_pkg::*;
#(
  parameter logic [15:0] RST_VAL = LFSR_SEED
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= seed;
    end else if (adv) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/pipe_field_scroller.sv
// Scrolling pipe field: tick divider, column shift
// register, pipe generation, collision and score.
module pipe_field_scroller
  import pipe_field_scroller_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int H_W      = DEF_H_W,
  parameter int GAP      = DEF_GAP,
  parameter int SPACING  = 8,
  parameter int RATE     = 750000,
  parameter int BIRD_COL = 1,
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input logic clk,
  input logic resetn,
  pipe_field_scroller_if.slave bus
);

  localparam int CW = H_W + 1;
  localparam int DW = $clog2(RATE);
  localparam int SW = $clog2(SPACING);
  localparam int RW = $clog2(COLS);

  localparam logic [H_W-1:0] MAXLO =
    H_W'(2**H_W - 1 - GAP);
  localparam logic [RW:0] COLS_W =
    (RW+1)'(COLS);
  localparam logic [DW-1:0] DIV_TOP =
    DW'(RATE - 1);
  localparam logic [SW-1:0] SP_TOP =
    SW'(SPACING - 1);

  logic [COLS*CW-1:0] field;
  logic [DW-1:0]      div;
  logic [SW-1:0]      gap_cnt;
  logic               hit_q;
  logic [15:0]        score_q;
  logic               rd_pipe_q;
  logic [H_W-1:0]     rd_lo_q;
  logic [15:0]        lfsr_q;

  logic           en;
  logic           step;
  logic           hit_now;
  logic           bird_pipe;
  logic [CW-1:0]  ahead_col;
  logic [CW-1:0]  next_col;
  logic [CW-1:0]  rd_word;
  logic [H_W-1:0] c;
  logic [H_W-1:0] g;
  logic [H_W:0]   gap_top;
  logic           unused_lfsr;

  dr_lfsr16 #(
    .RST_VAL(SEED)
  ) u_lfsr (
    .clk   (clk),
    .resetn(resetn),
    .load  (bus.start),
    .seed  (SEED),
    .adv   (step),
    .q     (lfsr_q)
  );

  assign en   = bus.run && !hit_q && !bus.start;
  assign step = en && (div == '0);

  // Collision looks at the column that lands on
  // BIRD_COL with this step; score at the one leaving.
  assign ahead_col = field[(BIRD_COL+1)*CW +: CW];
  assign bird_pipe = field[BIRD_COL*CW + H_W];

  assign c           = lfsr_q[H_W-1:0];
  assign unused_lfsr = ^lfsr_q[15:H_W];

  always_comb begin
    g = c;
    unique case (1'b1)
      (c == '0):    g = H_W'(1);
      (c > MAXLO):  g = c - MAXLO;
      default:      g = c;
    endcase
  end

  assign next_col =
    (gap_cnt == '0) ? {1'b1, g} : '0;

  assign gap_top =
    {1'b0, ahead_col[H_W-1:0]} + CW'(GAP);

  assign hit_now =
    (bus.bird_h == '0) ||
    (ahead_col[H_W] &&
     ((bus.bird_h < ahead_col[H_W-1:0]) ||
      ({1'b0, bus.bird_h} >= gap_top)));

  always_comb begin
    rd_word = '0;
    if ({1'b0, bus.rd_col} < COLS_W) begin
      rd_word =
        field[int'(bus.rd_col)*CW +: CW];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      field     <= '0;
      div       <= DIV_TOP;
      gap_cnt   <= SP_TOP;
      hit_q     <= 1'b0;
      score_q   <= '0;
      rd_pipe_q <= 1'b0;
      rd_lo_q   <= '0;
    end else if (bus.start) begin
      field     <= '0;
      div       <= DIV_TOP;
      gap_cnt   <= SP_TOP;
      hit_q     <= 1'b0;
      score_q   <= '0;
      rd_pipe_q <= 1'b0;
      rd_lo_q   <= '0;
    end else begin
      rd_pipe_q <= rd_word[H_W];
      rd_lo_q   <= rd_word[H_W-1:0];
      if (en) begin
        div <= (div == '0) ? DIV_TOP
                           : div - DW'(1);
      end
      if (step) begin
        field <= {next_col,
                  field[COLS*CW-1:CW]};
        gap_cnt <= (gap_cnt == '0)
                     ? SP_TOP
                     : gap_cnt - SW'(1);
        if (hit_now) begin
          hit_q <= 1'b1;
        end else if (bird_pipe &&
                     score_q != 16'hFFFF) begin
          score_q <= score_q + 16'd1;
        end
      end
    end
  end

  assign bus.tick      = step;
  assign bus.hit       = hit_q;
  assign bus.score     = score_q;
  assign bus.rd_pipe   = rd_pipe_q;
  assign bus.rd_gap_lo = rd_lo_q;

endmodule

// File: tb/tb_pipe_field_scroller.sv
// Bench for pipe_field_scroller: directed scenarios
// plus random play against an array-based field model.
module tb_pipe_field_scroller;

  localparam int COLS    = 16;
  localparam int H_W     = 5;
  localparam int GAP     = 6;
  localparam int SPACING = 4;
  localparam int RATE    = 4;
  localparam int BIRD    = 1;
  localparam int RW      = 4;
  localparam int MAXLO   = (1 << H_W) - 1 - GAP;

  logic clk = 1'b0;
  logic resetn = 1'b1;

  always #5 clk = ~clk;

  pipe_field_scroller_if #(
    .H_W(H_W), .RW(RW)
  ) bus ();

  pipe_field_scroller #(
    .COLS(COLS), .H_W(H_W), .GAP(GAP),
    .SPACING(SPACING), .RATE(RATE),
    .BIRD_COL(BIRD), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  bit        m_pipe[COLS];
  int        m_lo[COLS];
  int        m_div, m_cnt, m_score, m_rdl;
  bit        m_hit, m_rdp;
  bit [15:0] m_lfsr;
  bit        obs_tick, exp_tick;

  function automatic void model_clear();
    for (int i = 0; i < COLS; i++) begin
      m_pipe[i] = 1'b0;
      m_lo[i] = 0;
    end
    m_div = RATE - 1;
    m_cnt = SPACING - 1;
    m_lfsr = 16'hACE1;
    m_score = 0;
    m_hit = 1'b0;
    m_rdp = 1'b0;
    m_rdl = 0;
  endfunction

  function automatic void model_edge(
    bit s, bit r, int b, int c
  );
    bit t, nh;
    int cc, g;
    if (s) begin
      model_clear();
      return;
    end
    m_rdp = (c < COLS) ? m_pipe[c] : 1'b0;
    m_rdl = (c < COLS) ? m_lo[c] : 0;
    t = r && !m_hit && m_div == 0;
    if (r && !m_hit) m_div = t ? RATE - 1 : m_div - 1;
    if (!t) return;
    nh = (b == 0) || (m_pipe[BIRD+1] &&
         (b < m_lo[BIRD+1] || b >= m_lo[BIRD+1] + GAP));
    if (m_pipe[BIRD] && !nh && m_score < 65535)
      m_score++;
    if (nh) m_hit = 1'b1;
    for (int i = 0; i < COLS - 1; i++) begin
      m_pipe[i] = m_pipe[i+1];
      m_lo[i] = m_lo[i+1];
    end
    if (m_cnt == 0) begin
      cc = int'(m_lfsr) % (1 << H_W);
      if (cc == 0) g = 1;
      else if (cc > MAXLO) g = cc - MAXLO;
      else g = cc;
      m_pipe[COLS-1] = 1'b1;
      m_lo[COLS-1] = g;
      m_cnt = SPACING - 1;
    end else begin
      m_pipe[COLS-1] = 1'b0;
      m_lo[COLS-1] = 0;
      m_cnt--;
    end
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400)
                       : (m_lfsr >> 1);
  endfunction

  function automatic int safe_h();
    if (m_pipe[BIRD+1]) return m_lo[BIRD+1] + 2;
    return 10;
  endfunction

  // One clock: drive at negedge, sample tick before
  // the edge, advance the model at the edge.
  task automatic step(bit s, bit r, int b, int c);
    @(negedge clk);
    bus.start = s;
    bus.run = r;
    bus.bird_h = H_W'(b);
    bus.rd_col = RW'(c);
    #1;
    obs_tick = bus.tick;
    exp_tick = r && !s && !m_hit && (m_div == 0);
    @(posedge clk);
    model_edge(s, r, b, c);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.run = 1'b0;
    bus.bird_h = '0;
    bus.rd_col = '0;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    checks++;
    if (bus.tick !== 1'b0 || bus.hit !== 1'b0 ||
        bus.score !== 16'd0 || bus.rd_pipe !== 1'b0 ||
        bus.rd_gap_lo !== 5'd0) begin
      failures++;
      $display("FAIL reset: tick=%b hit=%b score=%0d rd_pipe=%b rd_gap_lo=%0d, all should be 0",
               bus.tick, bus.hit, bus.score,
               bus.rd_pipe, bus.rd_gap_lo);
    end
    resetn = 1'b1;
  endtask

  task automatic test_scroll_score();
    int t = 0;
    bit first_seen = 1'b0;
    for (int i = 0; i < 120 && m_score == 0; i++) begin
      step(0, 1, safe_h(), COLS - 1);
      if (exp_tick) t++;
      checks++;
      if (obs_tick !== exp_tick || bus.hit !== m_hit ||
          bus.score !== 16'(m_score) ||
          bus.rd_pipe !== m_rdp ||
          bus.rd_gap_lo !== H_W'(m_rdl)) begin
        failures++;
        $display("FAIL scroll cyc%0d: tick=%b/%b hit=%b/%b score=%0d/%0d rd=%b,%0d/%b,%0d",
                 i, obs_tick, exp_tick, bus.hit, m_hit,
                 bus.score, m_score, bus.rd_pipe,
                 bus.rd_gap_lo, m_rdp, m_rdl);
      end
      if (t == 4 && !exp_tick && !first_seen) begin
        first_seen = 1'b1;
        checks++;
        if (bus.rd_pipe !== 1'b1 ||
            bus.rd_gap_lo !== 5'd3) begin
          failures++;
          $display("FAIL first_pipe: rd_pipe=%b gap_lo=%0d, want 1 and 3",
                   bus.rd_pipe, bus.rd_gap_lo);
        end
      end
    end
    checks++;
    if (t != 19 || bus.score !== 16'd1 ||
        bus.hit !== 1'b0) begin
      failures++;
      $display("FAIL first_score: ticks=%0d score=%0d hit=%b, want 19 1 0",
               t, bus.score, bus.hit);
    end
  endtask

  task automatic test_hit_above();
    int b, n;
    for (int i = 0; i < 80 && !m_hit; i++) begin
      b = (m_pipe[BIRD+1] && m_div == 0)
            ? m_lo[BIRD+1] + GAP : safe_h();
      step(0, 1, b, 0);
      checks++;
      if (obs_tick !== exp_tick) begin
        failures++;
        $display("FAIL hit_tick cyc%0d: tick=%b want %b",
                 i, obs_tick, exp_tick);
      end
    end
    checks++;
    if (bus.hit !== 1'b1 || bus.score !== 16'd1) begin
      failures++;
      $display("FAIL hit_above: hit=%b score=%0d, want 1 1",
               bus.hit, bus.score);
    end
    n = 0;
    repeat (20) begin
      step(0, 1, 10, 0);
      n += int'(obs_tick);
    end
    checks++;
    if (n != 0 || bus.hit !== 1'b1) begin
      failures++;
      $display("FAIL ticks_after_hit: ticks=%0d hit=%b, want 0 1",
               n, bus.hit);
    end
  endtask

  task automatic test_ground();
    step(1, 0, 10, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      checks++;
      if (bus.hit !== (i == 3) || bus.score !== 16'd0) begin
        failures++;
        $display("FAIL ground cyc%0d: hit=%b score=%0d, want %b 0",
                 i, bus.hit, bus.score, (i == 3));
      end
    end
  endtask

  task automatic test_pause();
    int n = 0;
    step(1, 0, 10, 15);
    step(0, 1, 10, 15);
    step(0, 1, 10, 15);
    repeat (20) begin
      step(0, 0, 10, 15);
      n += int'(obs_tick);
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL pause: ticks=%0d want 0", n);
    end
    step(0, 1, 10, 15);
    checks++;
    if (obs_tick !== 1'b0) begin
      failures++;
      $display("FAIL resume1: tick=%b want 0", obs_tick);
    end
    step(0, 1, 10, 15);
    checks++;
    if (obs_tick !== 1'b1) begin
      failures++;
      $display("FAIL resume2: tick=%b want 1", obs_tick);
    end
    repeat (14) step(0, 1, safe_h(), 15);
    checks++;
    if (bus.rd_pipe !== 1'b1 || bus.rd_gap_lo !== 5'd3) begin
      failures++;
      $display("FAIL pause_pipe: rd_pipe=%b gap_lo=%0d, want 1 3",
               bus.rd_pipe, bus.rd_gap_lo);
    end
    step(1, 1, 10, 15);
    checks++;
    if (obs_tick !== 1'b0 || bus.rd_pipe !== 1'b0 ||
        bus.rd_gap_lo !== 5'd0 || bus.hit !== 1'b0 ||
        bus.score !== 16'd0) begin
      failures++;
      $display("FAIL start_clear: tick=%b rd=%b,%0d hit=%b score=%0d, want all 0",
               obs_tick, bus.rd_pipe, bus.rd_gap_lo,
               bus.hit, bus.score);
    end
    step(0, 0, 10, 15);
    checks++;
    if (bus.rd_pipe !== 1'b0 || bus.rd_gap_lo !== 5'd0) begin
      failures++;
      $display("FAIL field_cleared: rd=%b,%0d want 0,0",
               bus.rd_pipe, bus.rd_gap_lo);
    end
  endtask

  task automatic test_random();
    bit s, r;
    int b, c;
    step(1, 0, 10, 0);
    for (int i = 0; i < 800; i++) begin
      s = ($urandom_range(0, 99) == 0) ||
          (m_hit && $urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 7) != 0);
      b = ($urandom_range(0, 9) < 8)
            ? safe_h() : int'($urandom_range(0, 31));
      c = int'($urandom_range(0, COLS - 1));
      step(s, r, b, c);
      checks++;
      if (obs_tick !== exp_tick || bus.hit !== m_hit ||
          bus.score !== 16'(m_score) ||
          bus.rd_pipe !== m_rdp ||
          bus.rd_gap_lo !== H_W'(m_rdl)) begin
        failures++;
        $display("FAIL random cyc%0d: tick=%b/%b hit=%b/%b score=%0d/%0d rd=%b,%0d/%b,%0d",
                 i, obs_tick, exp_tick, bus.hit, m_hit,
                 bus.score, m_score, bus.rd_pipe,
                 bus.rd_gap_lo, m_rdp, m_rdl);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 10, 12);
    repeat (30) step(0, 1, safe_h(), 12);
    step(0, 1, 0, 12);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (bus.tick !== 1'b0 || bus.hit !== 1'b0 ||
        bus.score !== 16'd0 || bus.rd_pipe !== 1'b0 ||
        bus.rd_gap_lo !== 5'd0) begin
      failures++;
      $display("FAIL async_reset: tick=%b hit=%b score=%0d rd=%b,%0d, want all 0",
               bus.tick, bus.hit, bus.score,
               bus.rd_pipe, bus.rd_gap_lo);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 10, 15);
      checks++;
      if (obs_tick !== exp_tick || bus.hit !== m_hit) begin
        failures++;
        $display("FAIL post_reset cyc%0d: tick=%b/%b hit=%b/%b",
                 i, obs_tick, exp_tick, bus.hit, m_hit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scroll_score();
    test_hit_above();
    test_ground();
    test_pause();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
